// File: rtl/demux4_stream_pkg.sv
// demux4_pkg: shared state type and channel geometry for the 1-to-4 stream demux
package demux4_pkg;
  typedef enum logic {EMPTY, FULL} demux_state_t;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/demux4_stream_if.sv
// demux4_stream_if: single input stream plus four valid/ready output channels sharing one data bus
interface demux4_stream_if import demux4_pkg::*; #(parameter int N = 1);
  logic [N-1:0]      in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      out_data;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  modport slave (input in_data, in_sel, in_valid, out_ready, output in_ready, out_data, out_valid);
  modport master (output in_data, in_sel, in_valid, out_ready, input in_ready, out_data, out_valid);
endinterface

// File: rtl/demux4_stream_decoder.sv
// decoder2to4: one-hot decode of a 2-bit index, all zeros when disabled
module decoder2to4 (
  input  logic [1:0] sel_i,
  input  logic       en_i,
  output logic [3:0] dec_o
);
  assign dec_o = en_i ? 4'b0001 << sel_i : 4'b0000;
endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 valid/ready demultiplexer with a one-word holding register
module demux4_stream import demux4_pkg::*; #(parameter int N = 1) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  demux4_stream_if.slave  s,
  output logic            busy
);
  demux_state_t     state_q;
  logic [N-1:0]     data_q;
  logic [SEL_W-1:0] sel_q;
  logic             xfer, accept;
  assign busy       = state_q == FULL;
  assign xfer       = busy & s.out_ready[sel_q];
  assign s.in_ready = !rst & !flush & (!busy | s.out_ready[sel_q]);
  assign accept     = s.in_valid & s.in_ready;
  assign s.out_data = data_q;
  decoder2to4 u_dec (.sel_i(sel_q), .en_i(busy), .dec_o(s.out_valid));
  // holding register: flush drops the word, accept (re)loads it, a lone transfer empties it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else if (accept) begin
      state_q <= FULL;
      data_q  <= s.in_data;
      sel_q   <= s.in_sel;
    end else if (xfer) begin
      state_q <= EMPTY;
    end
  end
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed plan cases plus random traffic against a queue-based reference model
module tb_demux4_stream;
  typedef struct { logic [7:0] d; logic [1:0] s; } word_t;
  logic clk, rst, flush, busy;
  int   n_vec, n_err;
  word_t      q[$];
  logic [7:0] last;
  demux4_stream_if #(.N(8)) bus ();
  demux4_stream #(.N(8)) dut (.clk(clk), .rst(rst), .flush(flush), .s(bus), .busy(busy));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic f, input logic v, input logic [7:0] d,
                      input logic [1:0] sl, input logic [3:0] rdy);
    logic er;
    rst = r; flush = f; bus.in_valid = v; bus.in_data = d; bus.in_sel = sl; bus.out_ready = rdy;
    #2;
    er = !r && !f && (q.size() == 0 || rdy[q[0].s]);
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, er});
    check("out_valid", {28'd0, bus.out_valid}, q.size() != 0 ? 32'd1 << q[0].s : 32'd0);
    check("out_data", {24'd0, bus.out_data}, {24'd0, last});
    check("busy", {31'd0, busy}, {31'd0, q.size() != 0});
    @(posedge clk);
    if (r) begin
      q.delete();
      last = 8'h00;
    end else if (f) begin
      q.delete();
    end else begin
      if (q.size() != 0 && rdy[q[0].s]) void'(q.pop_front());
      if (v && er) begin
        q.push_back('{d, sl});
        last = d;
      end
    end
    #1;
  endtask
  initial begin
    n_vec = 0; n_err = 0; last = 8'h00;
    rst = 1; flush = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.in_sel = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, 0, 8'h00, 2'd0, 4'b0000);
    step(0, 0, 0, 8'h00, 2'd0, 4'b0000);
    step(0, 0, 1, 8'h11, 2'd0, 4'b1111);
    step(0, 0, 1, 8'h22, 2'd1, 4'b1111);
    step(0, 0, 1, 8'h33, 2'd2, 4'b1111);
    step(0, 0, 1, 8'h44, 2'd3, 4'b1111);
    check("stream_last_data", {24'd0, bus.out_data}, 32'h44);
    check("stream_last_valid", {28'd0, bus.out_valid}, 32'b1000);
    step(0, 0, 1, 8'hA5, 2'd2, 4'b1111);
    repeat (3) step(0, 0, 1, 8'hEE, 2'd0, 4'b1011);
    check("stall_data", {24'd0, bus.out_data}, 32'hA5);
    step(0, 0, 0, 8'h00, 2'd0, 4'b0100);
    step(0, 0, 1, 8'h5A, 2'd1, 4'b0000);
    step(0, 0, 1, 8'hC3, 2'd3, 4'b0010);
    check("refill_valid", {28'd0, bus.out_valid}, 32'b1000);
    check("refill_data", {24'd0, bus.out_data}, 32'hC3);
    step(0, 0, 1, 8'h77, 2'd0, 4'b1000);
    step(0, 0, 0, 8'h00, 2'd0, 4'b0000);
    step(0, 1, 1, 8'h99, 2'd1, 4'b0000);
    check("flush_valid", {28'd0, bus.out_valid}, 32'd0);
    step(0, 0, 1, 8'h3C, 2'd2, 4'b0000);
    step(0, 0, 0, 8'h00, 2'd0, 4'b0000);
    step(1, 0, 0, 8'h00, 2'd0, 4'b0000);
    check("rst_busy", {31'd0, busy}, 32'd0);
    step(0, 0, 0, 8'h00, 2'd0, 4'b1111);
    step(0, 1, 0, 8'h00, 2'd0, 4'b0000);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
           8'($urandom), 2'($urandom), 4'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
